// File: rtl/rv_pkg.sv
// ----------------------------------------------------------------------------
// rv_pkg : shared RISC-V core types, result/width encodings, helpers
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package rv_pkg;

  localparam logic [1:0] RES_SRC_ALU = 2'b00;
  localparam logic [1:0] RES_SRC_MEM = 2'b01;
  localparam logic [1:0] RES_SRC_PC4 = 2'b10;

  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    LDONE = 1'b1
  } mem_state_t;

  typedef struct packed {
    logic [31:0] alu_result;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [4:0]  rd;
    logic [29:0] pc_p4;
    logic [1:0]  res_src;
    logic [2:0]  funct3;
    logic [31:0] rs2_val;
  } stage_t;

  function automatic logic [31:0] res_mux(
    input logic [1:0]  src,
    input logic [31:0] alu,
    input logic [31:0] mem,
    input logic [29:0] pc_p4
  );
    case (src)
      RES_SRC_ALU: res_mux = alu;
      RES_SRC_MEM: res_mux = mem;
      RES_SRC_PC4: res_mux = {pc_p4, 2'b00};
      default:     res_mux = '0;
    endcase
  endfunction

  // Stores have no unsigned variants, so only B/H/W are legal for them.
  function automatic logic ls_legal(input logic store, input logic [2:0] funct3);
    case (funct3)
      LS_B, LS_H, LS_W: ls_legal = 1'b1;
      LS_BU, LS_HU:     ls_legal = ~store;
      default:          ls_legal = 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/rv_lsu_align.sv
// ----------------------------------------------------------------------------
// rv_lsu_align : byte-lane alignment for stores, extraction/extension for loads
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rv_lsu_align
  import rv_pkg::*;
(
  input  logic [1:0]  i_addr,
  input  logic [2:0]  i_funct3,
  input  logic        i_store,
  input  logic [31:0] i_rs2,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load_data,
  output logic        o_fault
);

  logic [31:0] w_shifted;

  assign w_shifted = i_rdata >> {i_addr, 3'b000};

  always_comb begin
    o_be    = '0;
    o_wdata = '0;
    o_fault = 1'b0;
    case (i_funct3[1:0])
      2'b00: begin
        o_be    = 4'b0001 << i_addr;
        o_wdata = {4{i_rs2[7:0]}};
      end
      2'b01: begin
        o_be    = 4'b0011 << {i_addr[1], 1'b0};
        o_wdata = {2{i_rs2[15:0]}};
        o_fault = i_addr[0];
      end
      2'b10: begin
        o_be    = 4'b1111;
        o_wdata = i_rs2;
        o_fault = |i_addr;
      end
      default: o_fault = 1'b1;
    endcase
    if (!ls_legal(i_store, i_funct3)) begin
      o_fault = 1'b1;
    end
  end

  always_comb begin
    o_load_data = '0;
    case (i_funct3)
      LS_B:    o_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      LS_H:    o_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      LS_W:    o_load_data = w_shifted;
      LS_BU:   o_load_data = {24'd0, w_shifted[7:0]};
      LS_HU:   o_load_data = {16'd0, w_shifted[15:0]};
      default: o_load_data = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/rv_mem_stage.sv
// ----------------------------------------------------------------------------
// rv_mem_stage : memory pipeline stage, req/ack data bus with wait-state stall
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rv_mem_stage
  import rv_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_flush,
  input  logic [31:0] i_alu_result,
  input  logic        i_reg_write,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic [4:0]  i_rd,
  input  logic [29:0] i_pc_p4,
  input  logic [1:0]  i_res_src,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_rs2_val,
  output logic        o_dbus_req,
  output logic        o_dbus_we,
  output logic [29:0] o_dbus_addr,
  output logic [3:0]  o_dbus_be,
  output logic [31:0] o_dbus_wdata,
  input  logic        i_dbus_ack,
  input  logic [31:0] i_dbus_rdata,
  output logic [31:0] o_result,
  output logic [4:0]  o_rd,
  output logic        o_reg_write,
  output logic        o_mem_fault,
  output logic        o_stall
);

  stage_t      r_stage;
  stage_t      w_incoming;
  mem_state_t  r_state;
  mem_state_t  w_next_state;
  logic [31:0] r_load;

  logic        w_mem_op;
  logic        w_align_fault;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_load_data;
  logic        w_req;
  logic        w_stall;
  logic        w_fault;
  logic        w_reg_write;
  logic        w_load_capture;
  logic [31:0] w_result;

  assign w_incoming = '{
    alu_result: i_alu_result,
    reg_write:  i_reg_write,
    mem_read:   i_mem_read,
    mem_write:  i_mem_write,
    rd:         i_rd,
    pc_p4:      i_pc_p4,
    res_src:    i_res_src,
    funct3:     i_funct3,
    rs2_val:    i_rs2_val
  };

  assign w_mem_op = r_stage.mem_read | r_stage.mem_write;

  rv_lsu_align u_align (
    .i_addr      (r_stage.alu_result[1:0]),
    .i_funct3    (r_stage.funct3),
    .i_store     (r_stage.mem_write),
    .i_rs2       (r_stage.rs2_val),
    .i_rdata     (i_dbus_rdata),
    .o_be        (w_be),
    .o_wdata     (w_wdata),
    .o_load_data (w_load_data),
    .o_fault     (w_align_fault)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Stall has priority over flush so a waiting access is never discarded.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_stage <= '0;
      r_load  <= '0;
    end else begin
      if (w_load_capture) begin
        r_load <= w_load_data;
      end
      if (!w_stall) begin
        r_stage <= i_flush ? '0 : w_incoming;
      end
    end
  end

  always_comb begin
    w_next_state   = r_state;
    w_req          = 1'b0;
    w_stall        = 1'b0;
    w_fault        = 1'b0;
    w_reg_write    = 1'b0;
    w_load_capture = 1'b0;
    w_result       = res_mux(r_stage.res_src, r_stage.alu_result, r_load, r_stage.pc_p4);
    case (r_state)
      IDLE: begin
        if (!w_mem_op) begin
          w_reg_write = r_stage.reg_write;
        end else if (w_align_fault) begin
          w_fault = 1'b1;
        end else begin
          w_req = 1'b1;
          if (!i_dbus_ack) begin
            w_stall = 1'b1;
          end else if (r_stage.mem_write) begin
            w_reg_write = r_stage.reg_write;
          end else begin
            w_stall        = 1'b1;
            w_load_capture = 1'b1;
            w_next_state   = LDONE;
          end
        end
      end
      LDONE: begin
        w_result     = r_load;
        w_reg_write  = r_stage.reg_write;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Bus fields are zeroed whenever no request is outstanding.
  assign o_dbus_req   = w_req;
  assign o_dbus_we    = w_req & r_stage.mem_write;
  assign o_dbus_addr  = w_req ? r_stage.alu_result[31:2] : '0;
  assign o_dbus_be    = w_req ? w_be : '0;
  assign o_dbus_wdata = (w_req & r_stage.mem_write) ? w_wdata : '0;

  assign o_result     = w_result;
  assign o_rd         = r_stage.rd;
  assign o_reg_write  = w_reg_write;
  assign o_mem_fault  = w_fault;
  assign o_stall      = w_stall;

endmodule

`default_nettype wire

// File: tb/tb_rv_mem_stage.sv
// ----------------------------------------------------------------------------
// tb_rv_mem_stage : vector table, corner sequences and random model checks
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_rv_mem_stage;

  typedef struct packed {
    logic [31:0] alu;
    logic        rw;
    logic        mr;
    logic        mw;
    logic [4:0]  rd;
    logic [29:0] pc;
    logic [1:0]  src;
    logic [2:0]  f3;
    logic [31:0] rs2;
  } instr_t;

  typedef struct {
    logic [31:0] alu;
    logic        mr, mw;
    logic [2:0]  f3;
    logic [31:0] rs2;
    logic [1:0]  src;
    logic        rw;
    logic [29:0] pc;
    logic [31:0] rdata;
    logic        exp_req, exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic        exp_fault, ldone, chk_res;
    logic [31:0] exp_res;
    logic        exp_rw;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic [31:0] alu, rs2, wdata, rdata, result;
  logic        rw, mr, mw, req, we, ack, rw_o, fault, stall;
  logic [4:0]  rd, rd_o;
  logic [29:0] pc, addr;
  logic [1:0]  src;
  logic [2:0]  f3;
  logic [3:0]  be;

  int n_tests = 0;
  int n_fail  = 0;

  rv_mem_stage dut (
    .i_clk(clk), .i_reset(reset), .i_flush(flush), .i_alu_result(alu),
    .i_reg_write(rw), .i_mem_read(mr), .i_mem_write(mw), .i_rd(rd),
    .i_pc_p4(pc), .i_res_src(src), .i_funct3(f3), .i_rs2_val(rs2),
    .o_dbus_req(req), .o_dbus_we(we), .o_dbus_addr(addr), .o_dbus_be(be),
    .o_dbus_wdata(wdata), .i_dbus_ack(ack), .i_dbus_rdata(rdata),
    .o_result(result), .o_rd(rd_o), .o_reg_write(rw_o),
    .o_mem_fault(fault), .o_stall(stall)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_exec(input instr_t x);
    alu = x.alu; rw = x.rw; mr = x.mr; mw = x.mw; rd = x.rd;
    pc = x.pc; src = x.src; f3 = x.f3; rs2 = x.rs2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; flush = 1'b0; ack = 1'b0; rdata = '0;
    set_exec('0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---- reference model, from the access rules ----
  function automatic logic m_fault(input instr_t x);
    int nb;
    if (!(x.mr | x.mw)) return 1'b0;
    if (x.mw && !(x.f3 inside {3'd0, 3'd1, 3'd2})) return 1'b1;
    if (!x.mw && !(x.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
    nb = 1 << x.f3[1:0];
    return (int'(x.alu[1:0]) % nb) != 0;
  endfunction

  function automatic logic [3:0] m_be(input instr_t x);
    int nb, mask;
    nb   = 1 << x.f3[1:0];
    mask = ((1 << nb) - 1) << x.alu[1:0];
    return 4'(mask);
  endfunction

  function automatic logic [31:0] m_wdata(input instr_t x);
    case (x.f3[1:0])
      2'd0:    return {24'd0, x.rs2[7:0]} * 32'h01010101;
      2'd1:    return {16'd0, x.rs2[15:0]} * 32'h00010001;
      default: return x.rs2;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input instr_t x, input logic [31:0] d);
    logic [31:0] sh;
    sh = d >> (8 * x.alu[1:0]);
    case (x.f3)
      3'd0:    return 32'($signed(sh[7:0]));
      3'd1:    return 32'($signed(sh[15:0]));
      3'd4:    return sh & 32'h000000FF;
      3'd5:    return sh & 32'h0000FFFF;
      default: return sh;
    endcase
  endfunction

  function automatic instr_t rand_instr();
    instr_t x;
    int kind;
    x.alu = $urandom; x.rd = 5'($urandom); x.pc = 30'($urandom);
    x.rs2 = $urandom; x.f3 = 3'($urandom);
    kind  = $urandom_range(0, 3);
    case (kind)
      0: begin
        x.mr = 1'b0; x.mw = 1'b0; x.src = 2'($urandom); x.rw = 1'($urandom);
      end
      1: begin
        x.mr = 1'b1; x.mw = 1'b0; x.src = 2'b01; x.rw = 1'b1;
        case ($urandom_range(0, 4))
          0: x.f3 = 3'd0; 1: x.f3 = 3'd1; 2: x.f3 = 3'd2; 3: x.f3 = 3'd4; default: x.f3 = 3'd5;
        endcase
      end
      2: begin
        x.mr = 1'b0; x.mw = 1'b1; x.src = 2'b00; x.rw = 1'b0;
        x.f3 = 3'($urandom_range(0, 2));
      end
      default: begin
        x.mr = 1'($urandom); x.mw = ~x.mr; x.src = x.mr ? 2'b01 : 2'b00; x.rw = x.mr;
      end
    endcase
    if (kind != 0 && $urandom_range(0, 3) != 0) begin
      if (x.f3[1:0] == 2'd1) x.alu[0] = 1'b0;
      if (x.f3[1:0] == 2'd2) x.alu[1:0] = 2'b00;
    end
    return x;
  endfunction

  vec_t   tbl[16];
  instr_t rlist[150];

  initial begin
    instr_t x, cur, nxt;
    logic [31:0] last_load, d;
    int waits;
    logic is_mem, f;

    reset = 1'b1; flush = 1'b0; ack = 1'b0; rdata = '0;
    set_exec('{alu: 32'hFFFFFFFF, rw: 1'b1, mr: 1'b1, mw: 1'b0, rd: 5'd31,
               pc: '1, src: 2'b10, f3: 3'd2, rs2: '1});
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst_req", {31'd0, req}, 0);       chk("rst_we", {31'd0, we}, 0);
    chk("rst_addr", {2'd0, addr}, 0);      chk("rst_be", {28'd0, be}, 0);
    chk("rst_wdata", wdata, 0);            chk("rst_result", result, 0);
    chk("rst_rd", {27'd0, rd_o}, 0);       chk("rst_rw", {31'd0, rw_o}, 0);
    chk("rst_fault", {31'd0, fault}, 0);   chk("rst_stall", {31'd0, stall}, 0);
    do_reset();

    // alu mr mw f3 rs2 src rw pc rdata | req we be wdata fault ldone chk res rw
    tbl[0]  = '{32'h6,   0,1,3'd1,32'h1234ABCD,2'd0,0,30'd0,32'h0,        1,1,4'hC,32'hABCDABCD,0,0,1,32'h6,0};
    tbl[1]  = '{32'h203, 1,0,3'd0,32'h0,       2'd1,1,30'd0,32'h80FFFF7F, 1,0,4'h8,32'h0,0,1,1,32'hFFFFFF80,1};
    tbl[2]  = '{32'h203, 1,0,3'd4,32'h0,       2'd1,1,30'd0,32'h80FFFF7F, 1,0,4'h8,32'h0,0,1,1,32'h00000080,1};
    tbl[3]  = '{32'h202, 1,0,3'd1,32'h0,       2'd1,1,30'd0,32'h80FFFF7F, 1,0,4'hC,32'h0,0,1,1,32'hFFFF80FF,1};
    tbl[4]  = '{32'h202, 1,0,3'd5,32'h0,       2'd1,1,30'd0,32'h80FFFF7F, 1,0,4'hC,32'h0,0,1,1,32'h000080FF,1};
    tbl[5]  = '{32'h100, 1,0,3'd2,32'h0,       2'd1,1,30'd0,32'h80FFFF7F, 1,0,4'hF,32'h0,0,1,1,32'h80FFFF7F,1};
    tbl[6]  = '{32'h102, 1,0,3'd2,32'h0,       2'd1,1,30'd0,32'h12345678, 0,0,4'h0,32'h0,1,0,0,32'h0,0};
    tbl[7]  = '{32'h101, 0,1,3'd0,32'h000000A5,2'd0,0,30'd0,32'h0,        1,1,4'h2,32'hA5A5A5A5,0,0,1,32'h101,0};
    tbl[8]  = '{32'h100, 0,1,3'd2,32'hDEADBEEF,2'd0,0,30'd0,32'h0,        1,1,4'hF,32'hDEADBEEF,0,0,1,32'h100,0};
    tbl[9]  = '{32'h3,   0,1,3'd1,32'h0,       2'd0,0,30'd0,32'h0,        0,0,4'h0,32'h0,1,0,0,32'h0,0};
    tbl[10] = '{32'h0,   0,1,3'd4,32'h0,       2'd0,0,30'd0,32'h0,        0,0,4'h0,32'h0,1,0,0,32'h0,0};
    tbl[11] = '{32'h0,   1,0,3'd3,32'h0,       2'd1,1,30'd0,32'h0,        0,0,4'h0,32'h0,1,0,0,32'h0,0};
    tbl[12] = '{32'h12345678,0,0,3'd0,32'h0,   2'd0,1,30'd0,32'h0,        0,0,4'h0,32'h0,0,0,1,32'h12345678,1};
    tbl[13] = '{32'h0,   0,0,3'd0,32'h0,       2'd2,1,30'h0ABCDEF1,32'h0, 0,0,4'h0,32'h0,0,0,1,32'h2AF37BC4,1};
    tbl[14] = '{32'hFFFFFFFF,0,0,3'd0,32'h0,   2'd3,1,30'd0,32'h0,        0,0,4'h0,32'h0,0,0,1,32'h0,1};
    tbl[15] = '{32'h4,   0,0,3'd0,32'h0,       2'd1,1,30'd0,32'h0,        0,0,4'h0,32'h0,0,0,1,32'h80FFFF7F,1};

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      set_exec('{alu: tbl[i].alu, rw: tbl[i].rw, mr: tbl[i].mr, mw: tbl[i].mw, rd: 5'd5,
                 pc: tbl[i].pc, src: tbl[i].src, f3: tbl[i].f3, rs2: tbl[i].rs2});
      ack = 1'b0;
      @(negedge clk);
      set_exec('0);
      ack = 1'b1; rdata = tbl[i].rdata;
      #1;
      chk($sformatf("v%0d_req", i), {31'd0, req}, {31'd0, tbl[i].exp_req});
      chk($sformatf("v%0d_we", i), {31'd0, we}, {31'd0, tbl[i].exp_we});
      chk($sformatf("v%0d_addr", i), {2'd0, addr}, tbl[i].exp_req ? {2'd0, tbl[i].alu[31:2]} : 32'd0);
      chk($sformatf("v%0d_be", i), {28'd0, be}, {28'd0, tbl[i].exp_be});
      chk($sformatf("v%0d_wdata", i), wdata, tbl[i].exp_wdata);
      chk($sformatf("v%0d_fault", i), {31'd0, fault}, {31'd0, tbl[i].exp_fault});
      chk($sformatf("v%0d_stall", i), {31'd0, stall}, {31'd0, tbl[i].ldone});
      if (tbl[i].ldone) begin
        @(negedge clk);
        ack = 1'b0;
        #1;
        chk($sformatf("v%0d_ldone_stall", i), {31'd0, stall}, 0);
      end
      if (tbl[i].chk_res) chk($sformatf("v%0d_result", i), result, tbl[i].exp_res);
      chk($sformatf("v%0d_rw", i), {31'd0, rw_o}, {31'd0, tbl[i].exp_rw});
    end

    // SW with two wait states
    @(negedge clk);
    set_exec('{alu: 32'h100, rw: 0, mr: 0, mw: 1, rd: 0, pc: 0, src: 0, f3: 3'd2, rs2: 32'hDEADBEEF});
    ack = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      set_exec('0);
      ack = (c == 2);
      #1;
      chk($sformatf("sw_req%0d", c), {31'd0, req}, 1);
      chk($sformatf("sw_addr%0d", c), {2'd0, addr}, 32'h40);
      chk($sformatf("sw_be%0d", c), {28'd0, be}, 32'hF);
      chk($sformatf("sw_stall%0d", c), {31'd0, stall}, (c == 2) ? 0 : 1);
    end
    @(negedge clk);
    ack = 1'b0;
    #1;
    chk("sw_req_after", {31'd0, req}, 0);

    // Load with three wait states while flush is held
    @(negedge clk);
    set_exec('{alu: 32'h40, rw: 1, mr: 1, mw: 0, rd: 5'd9, pc: 0, src: 2'b01, f3: 3'd2, rs2: 0});
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      set_exec('{alu: 32'h55, rw: 1, mr: 0, mw: 0, rd: 5'd3, pc: 0, src: 0, f3: 0, rs2: 0});
      flush = 1'b1;
      ack = (c == 3); rdata = 32'h11223344;
      #1;
      chk($sformatf("fl_req%0d", c), {31'd0, req}, 1);
      chk($sformatf("fl_stall%0d", c), {31'd0, stall}, 1);
      chk($sformatf("fl_rw%0d", c), {31'd0, rw_o}, 0);
    end
    @(negedge clk);
    ack = 1'b0;
    #1;
    chk("fl_ld_result", result, 32'h11223344);
    chk("fl_ld_rw", {31'd0, rw_o}, 1);
    chk("fl_ld_rd", {27'd0, rd_o}, 9);
    chk("fl_ld_stall", {31'd0, stall}, 0);
    @(negedge clk);
    flush = 1'b0;
    set_exec('0);
    #1;
    chk("fl_bubble_rd", {27'd0, rd_o}, 0);
    chk("fl_bubble_rw", {31'd0, rw_o}, 0);
    chk("fl_bubble_result", result, 0);

    // Reset during an outstanding load, then a late ack
    @(negedge clk);
    set_exec('{alu: 32'h80, rw: 1, mr: 1, mw: 0, rd: 5'd4, pc: 0, src: 2'b01, f3: 3'd2, rs2: 0});
    @(negedge clk);
    set_exec('0);
    #1;
    chk("rm_req_before", {31'd0, req}, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; ack = 1'b1; rdata = 32'hCAFEF00D;
    #1;
    chk("rm_req", {31'd0, req}, 0);
    chk("rm_stall", {31'd0, stall}, 0);
    chk("rm_rw", {31'd0, rw_o}, 0);
    @(negedge clk);
    ack = 1'b0;
    #1;
    chk("rm_rw_next", {31'd0, rw_o}, 0);
    chk("rm_result_next", result, 0);
    chk("rm_rd_next", {27'd0, rd_o}, 0);

    // Random instruction stream against the model
    do_reset();
    last_load = '0;
    for (int k = 0; k < 150; k++) rlist[k] = rand_instr();
    @(negedge clk);
    set_exec(rlist[0]);
    ack = 1'b0;
    for (int k = 0; k < 150; k++) begin
      cur    = rlist[k];
      nxt    = (k < 149) ? rlist[k + 1] : '0;
      is_mem = cur.mr | cur.mw;
      f      = m_fault(cur);
      if (!is_mem || f) begin
        @(negedge clk);
        set_exec(nxt);
        ack = 1'($urandom); rdata = $urandom;
        #1;
        chk($sformatf("r%0d_req", k), {31'd0, req}, 0);
        chk($sformatf("r%0d_stall", k), {31'd0, stall}, 0);
        chk($sformatf("r%0d_fault", k), {31'd0, fault}, {31'd0, f});
        chk($sformatf("r%0d_rw", k), {31'd0, rw_o}, is_mem ? 32'd0 : {31'd0, cur.rw});
        chk($sformatf("r%0d_rd", k), {27'd0, rd_o}, {27'd0, cur.rd});
        if (!is_mem) begin
          case (cur.src)
            2'd0:    x.alu = cur.alu;
            2'd1:    x.alu = last_load;
            2'd2:    x.alu = {cur.pc, 2'b00};
            default: x.alu = 32'd0;
          endcase
          chk($sformatf("r%0d_result", k), result, x.alu);
        end
      end else begin
        waits = $urandom_range(0, 3);
        d = '0;
        for (int c = 0; c <= waits; c++) begin
          @(negedge clk);
          set_exec(nxt);
          ack = (c == waits); rdata = $urandom;
          if (c == waits) d = rdata;
          #1;
          chk($sformatf("r%0d_req%0d", k, c), {31'd0, req}, 1);
          chk($sformatf("r%0d_we%0d", k, c), {31'd0, we}, {31'd0, cur.mw});
          chk($sformatf("r%0d_addr%0d", k, c), {2'd0, addr}, {2'd0, cur.alu[31:2]});
          chk($sformatf("r%0d_be%0d", k, c), {28'd0, be}, {28'd0, m_be(cur)});
          if (cur.mw) chk($sformatf("r%0d_wdata%0d", k, c), wdata, m_wdata(cur));
          chk($sformatf("r%0d_stall%0d", k, c), {31'd0, stall}, {31'd0, (c < waits) || cur.mr});
          chk($sformatf("r%0d_rw%0d", k, c), {31'd0, rw_o}, 0);
        end
        if (cur.mr) begin
          @(negedge clk);
          set_exec(nxt);
          ack = 1'($urandom); rdata = $urandom;
          #1;
          last_load = m_load(cur, d);
          chk($sformatf("r%0d_ld_req", k), {31'd0, req}, 0);
          chk($sformatf("r%0d_ld_stall", k), {31'd0, stall}, 0);
          chk($sformatf("r%0d_ld_result", k), result, last_load);
          chk($sformatf("r%0d_ld_rw", k), {31'd0, rw_o}, {31'd0, cur.rw});
          chk($sformatf("r%0d_ld_rd", k), {27'd0, rd_o}, {27'd0, cur.rd});
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
